// File: rtl/j2_io_ctrl.sv
// -----------------------------------------------------------------------------
// j2_io_ctrl
// Memory-mapped I/O controller between the j2 core I/O port and the board
// peripherals: LED bank, UART transmit path and a buffered UART receive path.
//
// Parameters
//   WIDTH     core data width (>= 16)
//   LED_COUNT number of LED outputs (1..WIDTH)
//   RX_DEPTH  RX FIFO depth in bytes (power of two, >= 2)
//
// Ports
//   clock, active_low_reset     rising-edge clock, synchronous active-low reset
//   io_write_enable/io_read_enable  one-cycle core access strobes
//   io_address, io_wdata        access address and write data
//   io_rdata                    registered read data, valid one cycle after a
//                               read strobe and held until the next read
//   leds                        LED register
//   uart_tx_data, uart_tx_wr    byte and one-cycle strobe to the UART transmitter
//   uart_tx_busy                transmitter busy
//   uart_rx_data, uart_rx_valid received byte from the UART receiver
//   uart_rx_rd                  one-cycle acknowledge to the UART receiver
//
// Address map (exact 16-bit match, others: writes ignored, reads return 0)
//   0x0000 W  TX data (dropped and tx_drop set when busy)
//   0x0002 R  RX pop, {valid, byte}
//   0x0004 R  status {count[15:8], tx_drop, rx_overflow, tx_busy, full, nonempty}
//             reading clears the two sticky flags
//   0x0010 RW LED register, 0x0012 set, 0x0014 clear, 0x0016 toggle
//   0x0018 W  1-based LED index set, only when J2_IO_LED_INDEX_EN is defined
//
// Optional feature macro: J2_IO_LED_INDEX_EN
// -----------------------------------------------------------------------------
module j2_io_ctrl #(
    parameter int WIDTH     = 32,
    parameter int LED_COUNT = 16,
    parameter int RX_DEPTH  = 8
) (
    input  logic                 clock,
    input  logic                 active_low_reset,
    input  logic                 io_write_enable,
    input  logic                 io_read_enable,
    input  logic [15:0]          io_address,
    input  logic [WIDTH-1:0]     io_wdata,
    output logic [WIDTH-1:0]     io_rdata,
    output logic [LED_COUNT-1:0] leds,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_wr,
    input  logic                 uart_tx_busy,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 uart_rx_rd
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0] A_TX     = 16'h0000;
    localparam logic [15:0] A_RX     = 16'h0002;
    localparam logic [15:0] A_STATUS = 16'h0004;
    localparam logic [15:0] A_LED    = 16'h0010;
    localparam logic [15:0] A_SET    = 16'h0012;
    localparam logic [15:0] A_CLR    = 16'h0014;
    localparam logic [15:0] A_TGL    = 16'h0016;
`ifdef J2_IO_LED_INDEX_EN
    localparam logic [15:0] A_IDX    = 16'h0018;
`endif

    // State
    logic [LED_COUNT-1:0] leds_q;
    logic [WIDTH-1:0]     rdata_q;
    logic [7:0]           tx_data_q;
    logic                 tx_wr_q;
    logic                 rx_rd_q;
    logic                 rx_ovf_q;
    logic                 tx_drop_q;
    logic [7:0]           rx_mem [RX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    // Decode
    logic                 wr_tx, tx_accept, tx_drop_set;
    logic                 status_rd, pop, rx_full, rx_nonempty;
    logic                 push_req, push, ovf_set;
    logic [LED_COUNT-1:0] leds_next;
    logic [LED_COUNT-1:0] wd_leds;
    logic [WIDTH-1:0]     rdata_next;
    logic [15:0]          status_word;
    logic [CNT_W-1:0]     count_next;

    // Upper write-data bits are intentionally ignored by most registers.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata;

    assign wr_tx       = io_write_enable && (io_address == A_TX);
    assign tx_accept   = wr_tx && !uart_tx_busy;
    assign tx_drop_set = wr_tx && uart_tx_busy;

    assign rx_full     = (count_q == CNT_W'(RX_DEPTH));
    assign rx_nonempty = (count_q != '0);
    assign status_rd   = io_read_enable && (io_address == A_STATUS);
    assign pop         = io_read_enable && (io_address == A_RX) && rx_nonempty;

    // RX handshake: the receiver holds uart_rx_valid until acknowledged. A
    // byte is taken whenever valid is high and no acknowledge went out the
    // previous cycle; the acknowledge (uart_rx_rd) follows exactly one cycle
    // later, so each byte is taken once. A full FIFO still acknowledges and
    // discards, unless a pop in the same cycle frees the slot.
    assign push_req = uart_rx_valid && !rx_rd_q;
    assign push     = push_req && (!rx_full || pop);
    assign ovf_set  = push_req && rx_full && !pop;

    assign status_word = {8'(count_q), 3'b000, tx_drop_q, rx_ovf_q,
                          uart_tx_busy, rx_full, rx_nonempty};

    assign wd_leds = io_wdata[LED_COUNT-1:0];

    always_comb begin
        leds_next = leds_q;
        if (io_write_enable) begin
            case (io_address)
                A_LED: leds_next = wd_leds;
                A_SET: leds_next = leds_q | wd_leds;
                A_CLR: leds_next = leds_q & ~wd_leds;
                A_TGL: leds_next = leds_q ^ wd_leds;
`ifdef J2_IO_LED_INDEX_EN
                // Index 0 and indices beyond LED_COUNT match no bit.
                A_IDX: begin
                    for (int i = 0; i < LED_COUNT; i++) begin
                        if (io_wdata[8:0] == 9'(i + 1)) leds_next[i] = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Read data reflects state before this cycle's updates.
    always_comb begin
        rdata_next = '0;
        case (io_address)
            A_RX:     if (rx_nonempty) rdata_next = WIDTH'({1'b1, rx_mem[rd_ptr_q]});
            A_STATUS: rdata_next = WIDTH'(status_word);
            A_LED:    rdata_next = WIDTH'(leds_q);
            default:  ;
        endcase
    end

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!active_low_reset) begin
            leds_q    <= '0;
            rdata_q   <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            rx_rd_q   <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            leds_q  <= leds_next;
            tx_wr_q <= tx_accept;
            rx_rd_q <= push_req;
            count_q <= count_next;
            if (io_read_enable) rdata_q <= rdata_next;
            if (tx_accept) tx_data_q <= io_wdata[7:0];
            // A new event in the same cycle as a clearing status read wins.
            rx_ovf_q  <= ovf_set     | (rx_ovf_q  & ~status_rd);
            tx_drop_q <= tx_drop_set | (tx_drop_q & ~status_rd);
            if (push) begin
                rx_mem[wr_ptr_q] <= uart_rx_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign io_rdata     = rdata_q;
    assign leds         = leds_q;
    assign uart_tx_data = tx_data_q;
    assign uart_tx_wr   = tx_wr_q;
    assign uart_rx_rd   = rx_rd_q;

endmodule

// File: tb/tb_j2_io_ctrl.sv
module tb_j2_io_ctrl;

  localparam int WIDTH     = 32;
  localparam int LED_COUNT = 16;
  localparam int RX_DEPTH  = 8;

  logic                 clock = 1'b0;
  logic                 active_low_reset;
  logic                 io_write_enable, io_read_enable;
  logic [15:0]          io_address;
  logic [WIDTH-1:0]     io_wdata, io_rdata;
  logic [LED_COUNT-1:0] leds;
  logic [7:0]           uart_tx_data, uart_rx_data;
  logic                 uart_tx_wr, uart_tx_busy, uart_rx_valid, uart_rx_rd;

  j2_io_ctrl #(.WIDTH(WIDTH), .LED_COUNT(LED_COUNT), .RX_DEPTH(RX_DEPTH)) dut (
    .clock(clock), .active_low_reset(active_low_reset),
    .io_write_enable(io_write_enable), .io_read_enable(io_read_enable),
    .io_address(io_address), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .leds(leds), .uart_tx_data(uart_tx_data), .uart_tx_wr(uart_tx_wr),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_rd(uart_rx_rd)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: byte queue plus plain register values
  logic [7:0]  m_fifo[$];
  logic [15:0] m_leds;
  logic [31:0] m_rdata;
  logic [7:0]  m_tx_data;
  logic        m_tx_wr, m_rx_rd, m_ovf, m_drop;

  task automatic model_reset();
    m_fifo.delete();
    m_leds = 0; m_rdata = 0; m_tx_data = 0;
    m_tx_wr = 0; m_rx_rd = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic [15:0] addr,
                            input logic [31:0] wd, input logic busy,
                            input logic rxv, input logic [7:0] rxd);
    logic       acked_last;
    logic [8:0] n;
    acked_last = m_rx_rd;
    m_tx_wr = 0;
    m_rx_rd = 0;
    if (re) begin
      m_rdata = 0;
      if (addr == 16'h0002 && m_fifo.size() > 0) m_rdata = 32'h100 | 32'(m_fifo.pop_front());
      else if (addr == 16'h0004) begin
        m_rdata = {16'h0, 8'(m_fifo.size()), 3'b000, m_drop, m_ovf, busy,
                   m_fifo.size() == RX_DEPTH, m_fifo.size() != 0};
        m_drop = 0;
        m_ovf  = 0;
      end else if (addr == 16'h0010) m_rdata = 32'(m_leds);
    end
    if (we) begin
      case (addr)
        16'h0000: if (!busy) begin m_tx_data = wd[7:0]; m_tx_wr = 1; end else m_drop = 1;
        16'h0010: m_leds = wd[15:0];
        16'h0012: m_leds = m_leds | wd[15:0];
        16'h0014: m_leds = m_leds & ~wd[15:0];
        16'h0016: m_leds = m_leds ^ wd[15:0];
`ifdef J2_IO_LED_INDEX_EN
        16'h0018: begin
          n = wd[8:0];
          if (n >= 1 && n <= LED_COUNT) m_leds[n-1] = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    if (rxv && !acked_last) begin
      m_rx_rd = 1;
      if (m_fifo.size() < RX_DEPTH) m_fifo.push_back(rxd);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_model();
    chk("leds", 32'(leds), 32'(m_leds));
    chk("io_rdata", io_rdata, m_rdata);
    chk("uart_tx_wr", 32'(uart_tx_wr), 32'(m_tx_wr));
    chk("uart_tx_data", 32'(uart_tx_data), 32'(m_tx_data));
    chk("uart_rx_rd", 32'(uart_rx_rd), 32'(m_rx_rd));
  endtask

  // driver: called at a falling edge, drives one cycle, returns at the next falling edge
  task automatic cycle(input logic we, input logic re, input logic [15:0] addr,
                       input logic [31:0] wd, input logic busy,
                       input logic rxv, input logic [7:0] rxd);
    io_write_enable = we; io_read_enable = re; io_address = addr; io_wdata = wd;
    uart_tx_busy = busy; uart_rx_valid = rxv; uart_rx_data = rxd;
    model_step(we, re, addr, wd, busy, rxv, rxd);
    @(posedge clock);
    @(negedge clock);
    compare_model();
  endtask

  task automatic reset_cycle();
    active_low_reset = 0;
    io_write_enable = 1; io_read_enable = 1; io_address = 16'h0010; io_wdata = 32'hFFFF;
    uart_tx_busy = 0; uart_rx_valid = 1; uart_rx_data = 8'hAA;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    compare_model();
    active_low_reset = 1;
  endtask

  task automatic idle();
    cycle(0, 0, 16'h0, 32'h0, 0, 0, 8'h0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle(0, 0, 16'h0, 32'h0, 0, 1, b);
    chk("rx_rd_pulse", 32'(uart_rx_rd), 32'h1);
    idle();
  endtask

  task automatic read_expect(input string name, input logic [15:0] addr, input logic [31:0] exp);
    cycle(0, 1, addr, 32'h0, 0, 0, 8'h0);
    chk(name, io_rdata, exp);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        busy;
    logic [15:0] exp_leds;
    logic [31:0] exp_rdata;
    logic        exp_tx_wr;
    logic [7:0]  exp_tx_data;
  } vec_t;

  vec_t vecs[17];

`ifdef J2_IO_LED_INDEX_EN
  localparam logic [15:0] IDX_LEDS = 16'h01E6;
`else
  localparam logic [15:0] IDX_LEDS = 16'h01E2;
`endif

  logic [15:0] rand_addrs[9] = '{16'h0000, 16'h0002, 16'h0004, 16'h0010, 16'h0012,
                                  16'h0014, 16'h0016, 16'h0018, 16'h0006};

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0004, 32'h0,   1'b0, 16'h0000, 32'h0,   1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 16'h0010, 32'h0,   1'b0, 16'h0000, 32'h0,   1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 16'h0010, 32'hF0,  1'b0, 16'h00F0, 32'h0,   1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 16'h0012, 32'h3,   1'b0, 16'h00F3, 32'h0,   1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 16'h0014, 32'h10,  1'b0, 16'h00E3, 32'h0,   1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 16'h0016, 32'h101, 1'b0, 16'h01E2, 32'h0,   1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 16'h0010, 32'h0,   1'b0, 16'h01E2, 32'h1E2, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 32'h141, 1'b0, 16'h01E2, 32'h1E2, 1'b1, 8'h41};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 32'h0,   1'b0, 16'h01E2, 32'h1E2, 1'b0, 8'h41};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 32'h155, 1'b1, 16'h01E2, 32'h1E2, 1'b0, 8'h41};
    vecs[10] = '{1'b0, 1'b1, 16'h0004, 32'h0,   1'b1, 16'h01E2, 32'h14,  1'b0, 8'h41};
    vecs[11] = '{1'b0, 1'b1, 16'h0004, 32'h0,   1'b0, 16'h01E2, 32'h0,   1'b0, 8'h41};
    vecs[12] = '{1'b1, 1'b0, 16'h0018, 32'h3,   1'b0, IDX_LEDS, 32'h0,   1'b0, 8'h41};
    vecs[13] = '{1'b1, 1'b0, 16'h0018, 32'h0,   1'b0, IDX_LEDS, 32'h0,   1'b0, 8'h41};
    vecs[14] = '{1'b1, 1'b0, 16'h0018, 32'd17,  1'b0, IDX_LEDS, 32'h0,   1'b0, 8'h41};
    vecs[15] = '{1'b0, 1'b1, 16'h0010, 32'h0,   1'b0, IDX_LEDS, 32'(IDX_LEDS), 1'b0, 8'h41};
    vecs[16] = '{1'b0, 1'b1, 16'h0018, 32'h0,   1'b0, IDX_LEDS, 32'h0,   1'b0, 8'h41};

    io_write_enable = 0; io_read_enable = 0; io_address = 0; io_wdata = 0;
    uart_tx_busy = 0; uart_rx_valid = 0; uart_rx_data = 0; active_low_reset = 0;
    @(negedge clock);
    reset_cycle();
    reset_cycle();
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_rdata", io_rdata, 32'h0);

    // table-driven register and TX vectors
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd, vecs[i].busy, 0, 8'h0);
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
      chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_tx_wr", i), 32'(uart_tx_wr), 32'(vecs[i].exp_tx_wr));
      chk($sformatf("vec%0d_tx_data", i), 32'(uart_tx_data), 32'(vecs[i].exp_tx_data));
    end

    // fill, overflow, drain
    for (int b = 8'h11; b <= 8'h18; b++) push_byte(8'(b));
    read_expect("status_full", 16'h0004, 32'h0803);
    push_byte(8'h19);
    read_expect("status_overflow", 16'h0004, 32'h080B);
    for (int b = 8'h11; b <= 8'h18; b++) read_expect("rx_pop", 16'h0002, 32'h100 | 32'(b));
    read_expect("rx_pop_empty", 16'h0002, 32'h0);
    read_expect("status_empty", 16'h0004, 32'h0);

    // simultaneous pop and push while full
    for (int b = 8'h21; b <= 8'h28; b++) push_byte(8'(b));
    cycle(0, 1, 16'h0002, 32'h0, 0, 1, 8'h55);
    chk("pop_push_rdata", io_rdata, 32'h121);
    chk("pop_push_rx_rd", 32'(uart_rx_rd), 32'h1);
    idle();
    read_expect("pop_push_status", 16'h0004, 32'h0803);
    for (int b = 8'h22; b <= 8'h28; b++) read_expect("rx_pop2", 16'h0002, 32'h100 | 32'(b));
    read_expect("rx_pop_last", 16'h0002, 32'h155);
    read_expect("rx_pop_empty2", 16'h0002, 32'h0);

    // reset mid-transfer discards FIFO and pending strobes
    push_byte(8'h61);
    push_byte(8'h62);
    cycle(1, 0, 16'h0000, 32'h77, 0, 1, 8'h63);
    reset_cycle();
    chk("midreset_tx_wr", 32'(uart_tx_wr), 32'h0);
    chk("midreset_rx_rd", 32'(uart_rx_rd), 32'h0);
    chk("midreset_tx_data", 32'(uart_tx_data), 32'h0);
    read_expect("midreset_status", 16'h0004, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_addrs[$urandom_range(0, 8)], $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/j2_io_ctrl.md
Name: j2_io_ctrl

Overview:
Parametrised I/O controller between the j2 core's I/O port and the board peripherals: LED bank, UART transmit path and buffered UART receive path. Replaces the ad-hoc LED decode and unbuffered UART strobes in the top level with a memory-mapped register set. It adds an RX FIFO, registered read-back and set/clear/toggle LED operations. Sits in j2_top between j2_core (io_write_enable, io_read_enable, memory_address, data_out, io_data_in) and buart.

Parameters:
WIDTH, 32, core data width; must be at least 16.
LED_COUNT, 16, number of LED outputs, 1..WIDTH.
RX_DEPTH, 8, RX FIFO depth in bytes; power of two, at least 2.

Ports:
clock  in  1  system clock; all logic on rising edge
active_low_reset  in  1  synchronous, active-low reset
io_write_enable  in  1  core I/O write strobe, one cycle per access
io_read_enable  in  1  core I/O read strobe, one cycle per access
io_address  in  16  I/O address (core memory_address)
io_wdata  in  WIDTH  write data (core data_out)
io_rdata  out  WIDTH  read data to core (core io_data_in)
leds  out  LED_COUNT  LED register
uart_tx_data  out  8  byte to buart tx_data
uart_tx_wr  out  1  one-cycle transmit strobe to buart
uart_tx_busy  in  1  buart busy
uart_rx_data  in  8  buart rx_data
uart_rx_valid  in  1  buart valid
uart_rx_rd  out  1  one-cycle acknowledge to buart rd

Behaviour:
- Reset (active_low_reset low at a clock edge): leds=0, io_rdata=0, uart_tx_wr=0, uart_tx_data=0, uart_rx_rd=0, FIFO empty, overflow flag=0. Reset mid-transfer discards FIFO contents and any pending strobe.
- Address map (exact 16-bit match; other addresses: writes ignored, reads return 0):
  - 0x0000 W: TX data. If uart_tx_busy=0, uart_tx_data<=io_wdata[7:0] and uart_tx_wr=1 for exactly the next cycle. If busy, the write is dropped and tx_drop is set (sticky).
  - 0x0002 R: RX pop. Returns {valid, byte} in bits [8:0]. If the FIFO is non-empty, valid=1 and the head is popped. If empty, returns 0.
  - 0x0004 R: status. bit0=rx_nonempty, bit1=rx_full, bit2=uart_tx_busy, bit3=rx_overflow (sticky), bit4=tx_drop (sticky), bits[15:8]=FIFO count. Reading clears bits 3 and 4.
  - 0x0010 W: leds<=io_wdata[LED_COUNT-1:0]. R: returns leds zero-extended.
  - 0x0012 W: leds<=leds|wdata. 0x0014 W: leds<=leds&~wdata. 0x0016 W: leds<=leds^wdata.
- Read latency: io_rdata is registered, valid one cycle after io_read_enable, and held until the next read. Simultaneous read and write in the same cycle: both are performed.
- RX capture:
  - When uart_rx_valid=1 and uart_rx_rd was not asserted the previous cycle, push uart_rx_data and assert uart_rx_rd for one cycle. This gives one push per byte.
  - FIFO full on capture: byte discarded, uart_rx_rd still pulsed, rx_overflow set.
  - Simultaneous pop and push: both occur and count is unchanged. When full, pop first frees the slot, so no overflow.
  - Pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. Count is log2(RX_DEPTH)+1 bits.
- All strobes are single-cycle; no combinational path from inputs to outputs.

Optional Feature:
Macro J2_IO_LED_INDEX_EN.
- Defined: address 0x0018 W accepts a 1-based LED index n in io_wdata[8:0]. For 1<=n<=LED_COUNT, leds[n-1]<=1. n=0 or n>LED_COUNT is ignored. This provides legacy firmware compatibility.
- Not defined: 0x0018 is unmapped; writes are ignored and reads return 0.

Test Plan:
- Reset, then read 0x0004 and 0x0010 -> io_rdata=0 one cycle after each read; leds=0.
- Write 0x0010=0x00F0, then 0x0012=0x0003, 0x0014=0x0010, 0x0016=0x0101 -> leds 0x00F0, 0x00F3, 0x00E3, 0x01E2.
- Write 0x0000=0x141 with busy=0 -> uart_tx_data=0x41, uart_tx_wr high one cycle. Repeat with busy=1 -> no strobe; status bit4=1, cleared by that read.
- Push 0x11..0x18 (8 bytes, RX_DEPTH=8) -> status count=8, bit1=1. Push 0x19 -> overflow bit3=1, uart_rx_rd still pulsed. Pop 8 times -> 0x111..0x118, then 0x000.
- With FIFO full, a pop and a push of 0x55 in the same cycle -> count stays 8, no overflow; 0x55 is the last byte popped.
- With J2_IO_LED_INDEX_EN: write 0x0018=3 -> leds[2]=1. Write 0x0018=0 or 17 -> no change. Without the macro -> no change.
